// File: rtl/memory_gateway_master_if.sv
// Bundle of the core-side request/response handshakes and the gateway control/operand
// signals. The master modport is the gateway master's view; slave is the opposite side.
interface memory_gateway_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_wen;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_is_write;
  logic        rsp_error;

  logic [63:0] base_pointer;
  logic        ap_start;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;
  logic [63:0] memory_pointer;
  logic [63:0] addr;
  logic [15:0] wdata;
  logic        wen;
  logic [15:0] ap_return;

  modport master (
    input  req_valid, req_addr, req_wdata, req_wen,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_is_write, rsp_error,
    input  rsp_ready,
    input  base_pointer,
    output ap_start,
    input  ap_done, ap_idle, ap_ready,
    output memory_pointer, addr, wdata, wen,
    input  ap_return
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_wen,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_is_write, rsp_error,
    output rsp_ready,
    output base_pointer,
    input  ap_start,
    output ap_done, ap_idle, ap_ready,
    input  memory_pointer, addr, wdata, wen,
    output ap_return
  );
endinterface

// File: rtl/memory_gateway_master.sv
// Buffers core memory requests in a FIFO and drives them one at a time through an
// ap_start/ap_done gateway. Optional issue timeout: MEMORY_GATEWAY_MASTER_TIMEOUT_EN.
module memory_gateway_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                     clock,
  input logic                     reset_n,
  memory_gateway_master_if.master bus
);

  localparam int             PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [63:0] addr;
    logic [15:0] wdata;
    logic        wen;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, empty, push, pop;
  req_t             head;

  state_t      state_q, state_d;
  logic        ap_start_q, ap_start_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_is_write_q, rsp_is_write_d;
  logic [15:0] rsp_rdata_q, rsp_rdata_d;
  logic [63:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wen_q, wen_d;

`ifdef MEMORY_GATEWAY_MASTER_TIMEOUT_EN
  localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic              rsp_error_q, rsp_error_d;
`endif

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = bus.req_valid && !full;
  assign head  = fifo_mem[rd_ptr_q];

  // Queue storage carries no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr_q] <= '{bus.req_addr, bus.req_wdata, bus.req_wen};
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    pop            = 1'b0;
    ap_start_d     = ap_start_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_is_write_d = rsp_is_write_q;
    rsp_rdata_d    = rsp_rdata_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wen_d          = wen_q;
`ifdef MEMORY_GATEWAY_MASTER_TIMEOUT_EN
    tcnt_d         = tcnt_q;
    rsp_error_d    = rsp_error_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty && !rsp_valid_q && bus.ap_idle) begin
          pop        = 1'b1;
          addr_d     = head.addr;
          wdata_d    = head.wdata;
          wen_d      = head.wen;
          ap_start_d = 1'b1;
          state_d    = ISSUE;
`ifdef MEMORY_GATEWAY_MASTER_TIMEOUT_EN
          tcnt_d     = '0;
`endif
        end
      end
      ISSUE: begin
        if (bus.ap_done) begin
          // ap_return is only valid in the done cycle, so it is captured here.
          ap_start_d     = 1'b0;
          rsp_rdata_d    = wen_q ? 16'h0000 : bus.ap_return;
          rsp_is_write_d = wen_q;
          rsp_valid_d    = 1'b1;
          state_d        = RESP;
`ifdef MEMORY_GATEWAY_MASTER_TIMEOUT_EN
          rsp_error_d    = 1'b0;
        end else if (tcnt_q == TCNT_LAST) begin
          ap_start_d     = 1'b0;
          rsp_rdata_d    = 16'h0000;
          rsp_is_write_d = wen_q;
          rsp_error_d    = 1'b1;
          rsp_valid_d    = 1'b1;
          state_d        = RESP;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
`endif
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ap_start_q     <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_is_write_q <= 1'b0;
      rsp_rdata_q    <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      wen_q          <= 1'b0;
`ifdef MEMORY_GATEWAY_MASTER_TIMEOUT_EN
      tcnt_q         <= '0;
      rsp_error_q    <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ap_start_q     <= ap_start_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_is_write_q <= rsp_is_write_d;
      rsp_rdata_q    <= rsp_rdata_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wen_q          <= wen_d;
`ifdef MEMORY_GATEWAY_MASTER_TIMEOUT_EN
      tcnt_q         <= tcnt_d;
      rsp_error_q    <= rsp_error_d;
`endif
    end
  end

  assign bus.req_ready      = !full;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_is_write   = rsp_is_write_q;
  assign bus.ap_start       = ap_start_q;
  assign bus.memory_pointer = bus.base_pointer;
  assign bus.addr           = addr_q;
  assign bus.wdata          = wdata_q;
  assign bus.wen            = wen_q;

`ifdef MEMORY_GATEWAY_MASTER_TIMEOUT_EN
  assign bus.rsp_error = rsp_error_q;
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.ap_ready};
`else
  assign bus.rsp_error = 1'b0;
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.ap_ready, (TIMEOUT_CYCLES > 0)};
`endif

endmodule

// File: tb/tb_memory_gateway_master.sv
// Directed bench for memory_gateway_master: a behavioural gateway with programmable
// latency sits on the ap_* side; responses are logged and compared against hand values.
module tb_memory_gateway_master;

  localparam int TO_CYC = 16;
`ifdef MEMORY_GATEWAY_MASTER_TIMEOUT_EN
  localparam int LONG_LAT = 12;
`else
  localparam int LONG_LAT = 77;
`endif
  localparam logic [63:0] BASE = 64'h0000_1000_0000_0000;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  memory_gateway_master_if ifc ();

  memory_gateway_master #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural gateway: ap_start seen at edge S -> ap_done high in the cycle
  // after edge S+lat-1, so ap_start is high for lat+1 cycles. lat==0 never completes.
  logic [15:0] mem [256];
  int          lat = 3;
  bit          gw_hold = 1'b0;
  logic        gw_busy, gw_idle, gw_done;
  logic [15:0] gw_ret;
  int          gw_cnt;
  logic [63:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        lat_wen;
  int          starts = 0;
  int          viol = 0;
  int          rsp_n = 0;
  int          rsp_at_start[$];

  assign ifc.ap_idle   = gw_idle && !gw_hold;
  assign ifc.ap_done   = gw_done;
  assign ifc.ap_return = gw_ret;
  assign ifc.ap_ready  = gw_done;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gw_busy      <= 1'b0;
      gw_idle      <= 1'b1;
      gw_done      <= 1'b0;
      gw_ret       <= 16'h0;
      gw_cnt       <= 0;
      mem[8'h10]   <= 16'h1234;
    end else begin
      gw_done <= 1'b0;
      if (gw_done) gw_idle <= 1'b1;
      if (!gw_busy && ifc.ap_start && ifc.ap_idle && !gw_done) begin
        gw_busy   <= 1'b1;
        gw_idle   <= 1'b0;
        gw_cnt    <= lat - 2;
        lat_addr  <= ifc.addr;
        lat_wdata <= ifc.wdata;
        lat_wen   <= ifc.wen;
        starts    <= starts + 1;
        rsp_at_start.push_back(rsp_n);
      end else if (gw_busy) begin
        if (ifc.addr !== lat_addr || ifc.wdata !== lat_wdata ||
            ifc.wen !== lat_wen || ifc.ap_start !== 1'b1)
          viol <= viol + 1;
        if (lat != 0 && gw_cnt <= 0) begin
          gw_done <= 1'b1;
          gw_busy <= 1'b0;
          if (lat_wen) begin
            mem[lat_addr[7:0]] <= lat_wdata;
            gw_ret <= 16'hDEAD;
          end else begin
            gw_ret <= mem[lat_addr[7:0]];
          end
        end else begin
          gw_cnt <= gw_cnt - 1;
        end
      end
    end
  end

  typedef struct packed {
    logic        w;
    logic [15:0] d;
    logic        e;
  } rsp_t;
  rsp_t rsps[$];

  always @(negedge clock) begin
    if (reset_n && ifc.rsp_valid && ifc.rsp_ready) begin
      rsps.push_back('{ifc.rsp_is_write, ifc.rsp_rdata, ifc.rsp_error});
      rsp_n++;
    end
  end

  task automatic push(input logic [63:0] a, input logic [15:0] d, input logic w);
    bit ok;
    ok = 1'b0;
    ifc.req_addr  = a;
    ifc.req_wdata = d;
    ifc.req_wen   = w;
    ifc.req_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (ifc.req_ready) ok = 1'b1;
      @(negedge clock);
    end
    ifc.req_valid = 1'b0;
    if (!ok) chk("push_accept", 64'(ok), 64'd1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 400 && rsps.size() < n; i++) @(negedge clock);
    if (rsps.size() < n) chk("rsp_count", 64'(rsps.size()), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   hi;
    int   s0;
    int   n0;
    bit   flag;
    logic exp_w [5];
    logic [15:0] exp_d [5];

    ifc.req_valid    = 1'b0;
    ifc.req_addr     = '0;
    ifc.req_wdata    = '0;
    ifc.req_wen      = 1'b0;
    ifc.rsp_ready    = 1'b1;
    ifc.base_pointer = BASE;

    // Asynchronous reset, checked before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ap_start", 64'(ifc.ap_start), 64'd0);
    chk("rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(ifc.rsp_rdata), 64'd0);
    chk("rst_rsp_is_write", 64'(ifc.rsp_is_write), 64'd0);
    chk("rst_rsp_error", 64'(ifc.rsp_error), 64'd0);
    chk("rst_addr", ifc.addr, 64'd0);
    chk("rst_wdata", 64'(ifc.wdata), 64'd0);
    chk("rst_wen", 64'(ifc.wen), 64'd0);
    chk("rst_req_ready", 64'(ifc.req_ready), 64'd1);
    chk("memory_pointer", ifc.memory_pointer, BASE);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Single read with long gateway latency; minimum-latency timing.
    lat = LONG_LAT;
    ifc.req_addr = 64'h10; ifc.req_wdata = 16'h0; ifc.req_wen = 1'b0; ifc.req_valid = 1'b1;
    @(negedge clock);
    ifc.req_valid = 1'b0;
    chk("lat_start_after_T", 64'(ifc.ap_start), 64'd0);
    @(negedge clock);
    chk("lat_start_after_T1", 64'(ifc.ap_start), 64'd1);
    chk("issue_addr", ifc.addr, 64'h10);
    chk("issue_wen", 64'(ifc.wen), 64'd0);
    hi = 1;
    for (int i = 0; i < 500 && !ifc.ap_done; i++) begin
      @(negedge clock);
      if (ifc.ap_start) hi++;
    end
    chk("start_high_cycles", 64'(hi), 64'(LONG_LAT + 1));
    @(negedge clock);
    chk("rd_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
    chk("rd_start_cleared", 64'(ifc.ap_start), 64'd0);
    chk("rd_rdata", 64'(ifc.rsp_rdata), 64'h1234);
    chk("rd_is_write", 64'(ifc.rsp_is_write), 64'd0);
    chk("rd_error", 64'(ifc.rsp_error), 64'd0);
    wait_rsp(1);

    // Write then read back-to-back.
    lat = 4;
    rsps.delete();
    rsp_at_start.delete();
    push(64'h20, 16'hBEEF, 1'b1);
    push(64'h20, 16'h0000, 1'b0);
    wait_rsp(2);
    chk("wr_is_write", 64'(rsps[0].w), 64'd1);
    chk("wr_rdata_zero", 64'(rsps[0].d), 64'd0);
    chk("rb_is_write", 64'(rsps[1].w), 64'd0);
    chk("rb_rdata", 64'(rsps[1].d), 64'hBEEF);
    chk("rb_starts", 64'(rsp_at_start.size()), 64'd2);
    chk("rb_issue_after_rsp",
        64'((rsp_at_start.size() >= 2) ? rsp_at_start[1] - rsp_at_start[0] : -1), 64'd1);

    // FIFO fill with gateway held busy, fifth request waits for the first pop.
    lat = 3;
    rsps.delete();
    gw_hold = 1'b1;
    exp_w[0] = 1'b1; exp_d[0] = 16'h0000;
    exp_w[1] = 1'b0; exp_d[1] = 16'h1234;
    exp_w[2] = 1'b0; exp_d[2] = 16'hA5A5;
    exp_w[3] = 1'b1; exp_d[3] = 16'h0000;
    exp_w[4] = 1'b0; exp_d[4] = 16'h5A5A;
    push(64'h30, 16'hA5A5, 1'b1);
    push(64'h10, 16'h0000, 1'b0);
    push(64'h30, 16'h0000, 1'b0);
    push(64'h31, 16'h5A5A, 1'b1);
    chk("fifo_full_ready", 64'(ifc.req_ready), 64'd0);
    ifc.req_addr = 64'h31; ifc.req_wdata = 16'h0; ifc.req_wen = 1'b0; ifc.req_valid = 1'b1;
    flag = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (ifc.req_ready !== 1'b0) flag = 1'b0;
    end
    chk("fifo_full_held", 64'(flag), 64'd1);
    chk("fifo_no_issue_held", 64'(ifc.ap_start), 64'd0);
    gw_hold = 1'b0;
    flag = 1'b0;
    for (int i = 0; i < 50 && !flag; i++) begin
      if (ifc.req_ready) flag = 1'b1;
      @(negedge clock);
    end
    ifc.req_valid = 1'b0;
    chk("fifth_accepted", 64'(flag), 64'd1);
    wait_rsp(5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("order_w%0d", i), 64'(rsps[i].w), 64'(exp_w[i]));
      chk($sformatf("order_d%0d", i), 64'(rsps[i].d), 64'(exp_d[i]));
    end

    // Response back-pressure.
    rsps.delete();
    ifc.rsp_ready = 1'b0;
    push(64'h10, 16'h0000, 1'b0);
    push(64'h40, 16'h7777, 1'b1);
    for (int i = 0; i < 50 && !ifc.rsp_valid; i++) @(negedge clock);
    chk("bp_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
    s0 = starts;
    flag = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (ifc.rsp_valid !== 1'b1 || ifc.rsp_rdata !== 16'h1234 || ifc.rsp_is_write !== 1'b0)
        flag = 1'b0;
    end
    chk("bp_rsp_stable", 64'(flag), 64'd1);
    chk("bp_no_new_start", 64'(starts - s0), 64'd0);
    ifc.rsp_ready = 1'b1;
    wait_rsp(2);
    chk("bp_first_rdata", 64'(rsps[0].d), 64'h1234);
    chk("bp_second_write", 64'(rsps[1].w), 64'd1);
    chk("bp_next_issued", 64'(starts - s0), 64'd1);

    // Reset during ISSUE drops in-flight and queued work.
    lat = LONG_LAT;
    push(64'h10, 16'h0000, 1'b0);
    push(64'h10, 16'h0000, 1'b0);
    chk("mid_issue_start", 64'(ifc.ap_start), 64'd1);
    gw_hold = 1'b1;
    n0 = rsp_n;
    s0 = starts;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ap_start", 64'(ifc.ap_start), 64'd0);
    chk("mid_rst_rsp_valid", 64'(ifc.rsp_valid), 64'd0);
    chk("mid_rst_fifo_empty", 64'(ifc.req_ready), 64'd1);
    chk("mid_rst_addr", ifc.addr, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    flag = 1'b1;
    repeat (5) begin
      @(negedge clock);
      if (ifc.ap_start !== 1'b0) flag = 1'b0;
    end
    gw_hold = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (ifc.ap_start !== 1'b0 || ifc.rsp_valid !== 1'b0) flag = 1'b0;
    end
    chk("post_rst_quiet", 64'(flag), 64'd1);
    chk("post_rst_no_rsp", 64'(rsp_n - n0), 64'd0);
    chk("post_rst_no_start", 64'(starts - s0), 64'd0);

`ifdef MEMORY_GATEWAY_MASTER_TIMEOUT_EN
    // Gateway never completes: timeout after TO_CYC ISSUE cycles.
    lat = 0;
    push(64'h10, 16'h0000, 1'b0);
    hi = 0;
    for (int i = 0; i < 200 && !ifc.rsp_valid; i++) begin
      @(negedge clock);
      if (ifc.ap_start) hi++;
    end
    chk("to_issue_cycles", 64'(hi), 64'(TO_CYC));
    chk("to_rsp_valid", 64'(ifc.rsp_valid), 64'd1);
    chk("to_rsp_error", 64'(ifc.rsp_error), 64'd1);
    chk("to_rsp_rdata", 64'(ifc.rsp_rdata), 64'd0);
    chk("to_start_cleared", 64'(ifc.ap_start), 64'd0);
    @(negedge clock);
`endif

    chk("operand_stable", 64'(viol), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
